// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle MIPS main controller.
// A Moore FSM sequences fetch / decode / execute / memory / write-back over a
// shared ALU and a shared instruction/data memory. The only outputs that
// depend on an input are IRWrite/PCWrite in FETCH, which wait for mem_ready_i
// so the PC and instruction register advance only when the fetch completes.
// Memory handshake: the controller holds MemRead/MemWrite and IorD steady
// while in FETCH, MEMRD or MEMWR; the access completes on the rising edge
// where mem_ready_i=1, and the FSM leaves that state on that same edge.
// mem_ready_i is ignored in every other state.
module mc_main_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  instr_op_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        PCWriteCond_o,
    output logic        IorD_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        MemtoReg_o,
    output logic        IRWrite_o,
    output logic        RegWrite_o,
    output logic        RegDst_o,
    output logic        ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [1:0]  PCSource_o,
    output logic [2:0]  ALUOp_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [15:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b110;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic        illegal_q, illegal_d;
    logic [15:0] cnt_q, cnt_d;
    logic        retire;

    // State, latched opcode, sticky illegal flag and retire counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_RST;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic, opcode capture, illegal detection and retirement.
    always_comb begin
        state_d   = S_FETCH;
        op_d      = op_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = instr_op_i;
                case (instr_op_i)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R:             state_d = S_REXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                state_d = mem_ready_i ? S_FETCH : S_MEMWR;
                retire  = mem_ready_i;
            end
            S_REXEC:  state_d = S_RWB;
            S_RWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_IEXEC:  state_d = S_IWB;
            S_IWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + 16'd1 : cnt_q;
    end

    // Moore output decode; FETCH strobes additionally gated by mem_ready_i.
    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        MemtoReg_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegWrite_o    = 1'b0;
        RegDst_o      = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        PCSource_o    = 2'b00;
        ALUOp_o       = 3'b000;
        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALUOp_o   = ALU_ADD;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB_o = 2'b11;
                ALUOp_o   = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = ALU_ADD;
            end
            S_MEMRD: begin
                IorD_o    = 1'b1;
                MemRead_o = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg_o = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_MEMWR: begin
                IorD_o     = 1'b1;
                MemWrite_o = 1'b1;
            end
            S_REXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b00;
                ALUOp_o   = ALU_RTYPE;
            end
            S_RWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = ALU_SUB;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
            end
            S_IEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_IWB:    RegWrite_o = 1'b1;
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
            end
            default: ;
        endcase
    end

    assign state_o     = state_q;
    assign illegal_o   = illegal_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl. Inputs change on the falling edge, outputs
// are checked 1 time unit later, well away from the rising edge.
module tb_mc_main_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [5:0]  instr_op_i;
    logic        mem_ready_i;
    logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
    logic        MemtoReg_o, IRWrite_o, RegWrite_o, RegDst_o, ALUSrcA_o;
    logic [1:0]  ALUSrcB_o, PCSource_o;
    logic [2:0]  ALUOp_o;
    logic [3:0]  state_o;
    logic        illegal_o;
    logic [15:0] instr_cnt_o;

    int n_cmp;
    int n_err;

    mc_main_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_op_i    (instr_op_i),
        .mem_ready_i   (mem_ready_i),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .IorD_o        (IorD_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .MemtoReg_o    (MemtoReg_o),
        .IRWrite_o     (IRWrite_o),
        .RegWrite_o    (RegWrite_o),
        .RegDst_o      (RegDst_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .PCSource_o    (PCSource_o),
        .ALUOp_o       (ALUOp_o),
        .state_o       (state_o),
        .illegal_o     (illegal_o),
        .instr_cnt_o   (instr_cnt_o)
    );

    // Control word: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
    //                IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp}
    logic [16:0] ctl;
    assign ctl = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                  MemtoReg_o, IRWrite_o, RegWrite_o, RegDst_o, ALUSrcA_o,
                  ALUSrcB_o, PCSource_o, ALUOp_o};

    localparam logic [16:0] E_ZERO    = 17'd0;
    localparam logic [16:0] E_FETCH_W = {10'b0001000000, 2'b01, 2'b00, 3'b100};
    localparam logic [16:0] E_FETCH_R = {10'b1001001000, 2'b01, 2'b00, 3'b100};
    localparam logic [16:0] E_DECODE  = {10'b0000000000, 2'b11, 2'b00, 3'b100};
    localparam logic [16:0] E_MEMADR  = {10'b0000000001, 2'b10, 2'b00, 3'b100};
    localparam logic [16:0] E_MEMRD   = {10'b0011000000, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MEMWB   = {10'b0000010100, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_MEMWR   = {10'b0010100000, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_REXEC   = {10'b0000000001, 2'b00, 2'b00, 3'b010};
    localparam logic [16:0] E_RWB     = {10'b0000000110, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_BRANCH  = {10'b0100000001, 2'b00, 2'b01, 3'b110};
    localparam logic [16:0] E_IEX_ADD = {10'b0000000001, 2'b10, 2'b00, 3'b100};
    localparam logic [16:0] E_IEX_SLT = {10'b0000000001, 2'b10, 2'b00, 3'b101};
    localparam logic [16:0] E_IWB     = {10'b0000000100, 2'b00, 2'b00, 3'b000};
    localparam logic [16:0] E_JUMP    = {10'b1000000000, 2'b00, 2'b10, 3'b000};

    // Clock: 10 time-unit period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check state and control word for the current cycle, then advance.
    task automatic step(input string tag, input logic [3:0] st, input logic [16:0] c);
        #1;
        chk({tag, "/state"}, {28'd0, state_o}, {28'd0, st});
        chk({tag, "/ctl"}, {15'd0, ctl}, {15'd0, c});
        @(negedge clk_i);
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] cnt, input logic ill);
        chk({tag, "/cnt"}, {16'd0, instr_cnt_o}, {16'd0, cnt});
        chk({tag, "/illegal"}, {31'd0, illegal_o}, {31'd0, ill});
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_i       = 1'b0;
        mem_ready_i = 1'b0;
        instr_op_i  = 6'b000000;

        // Reset asserted between clock edges clears outputs at once.
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst/state", {28'd0, state_o}, 32'd0);
        chk("async_rst/ctl", {15'd0, ctl}, {15'd0, E_ZERO});
        chk_cnt("async_rst", 16'd0, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // R-type, zero wait: 1,2,7,8.
        mem_ready_i = 1'b1;
        instr_op_i  = 6'b000000;
        step("r_rst", 4'd0, E_ZERO);
        step("r_fetch", 4'd1, E_FETCH_R);
        step("r_decode", 4'd2, E_DECODE);
        step("r_rexec", 4'd7, E_REXEC);
        #1 chk_cnt("r_before", 16'd0, 1'b0);
        step("r_rwb", 4'd8, E_RWB);

        // lw with two wait cycles in MEMRD: 1,2,3,4,4,4,5.
        #1 chk_cnt("r_after", 16'd1, 1'b0);
        instr_op_i = 6'b100011;
        step("lw_fetch", 4'd1, E_FETCH_R);
        step("lw_decode", 4'd2, E_DECODE);
        mem_ready_i = 1'b0;
        instr_op_i  = 6'b111111;
        step("lw_memadr", 4'd3, E_MEMADR);
        step("lw_memrd0", 4'd4, E_MEMRD);
        step("lw_memrd1", 4'd4, E_MEMRD);
        mem_ready_i = 1'b1;
        step("lw_memrd2", 4'd4, E_MEMRD);
        step("lw_memwb", 4'd5, E_MEMWB);

        // beq then j, counter +2 over 6 cycles.
        #1 chk_cnt("lw_after", 16'd2, 1'b0);
        instr_op_i = 6'b000100;
        step("beq_fetch", 4'd1, E_FETCH_R);
        step("beq_decode", 4'd2, E_DECODE);
        instr_op_i = 6'b000010;
        step("beq_branch", 4'd9, E_BRANCH);
        step("j_fetch", 4'd1, E_FETCH_R);
        step("j_decode", 4'd2, E_DECODE);
        step("j_jump", 4'd12, E_JUMP);

        // Illegal opcode: 1,2,1, sticky flag, no retirement.
        #1 chk_cnt("bj_after", 16'd4, 1'b0);
        instr_op_i = 6'b111111;
        step("ill_fetch", 4'd1, E_FETCH_R);
        #1 chk_cnt("ill_decode", 16'd4, 1'b0);
        step("ill_decode", 4'd2, E_DECODE);
        #1 chk_cnt("ill_after", 16'd4, 1'b1);
        instr_op_i = 6'b001000;
        step("addi_fetch", 4'd1, E_FETCH_R);
        step("addi_decode", 4'd2, E_DECODE);
        step("addi_iexec", 4'd10, E_IEX_ADD);
        step("addi_iwb", 4'd11, E_IWB);

        // slti uses ALUOp 101 in IEXEC.
        #1 chk_cnt("addi_after", 16'd5, 1'b1);
        instr_op_i = 6'b001010;
        step("slti_fetch", 4'd1, E_FETCH_R);
        step("slti_decode", 4'd2, E_DECODE);
        step("slti_iexec", 4'd10, E_IEX_SLT);
        step("slti_iwb", 4'd11, E_IWB);

        // sw: FETCH waits once, MEMWR waits once, retires on ready.
        #1 chk_cnt("slti_after", 16'd6, 1'b1);
        instr_op_i  = 6'b101011;
        mem_ready_i = 1'b0;
        step("sw_fetch_wait", 4'd1, E_FETCH_W);
        mem_ready_i = 1'b1;
        step("sw_fetch", 4'd1, E_FETCH_R);
        step("sw_decode", 4'd2, E_DECODE);
        step("sw_memadr", 4'd3, E_MEMADR);
        mem_ready_i = 1'b0;
        step("sw_memwr0", 4'd6, E_MEMWR);
        #1 chk_cnt("sw_memwr1", 16'd6, 1'b1);
        mem_ready_i = 1'b1;
        step("sw_memwr1", 4'd6, E_MEMWR);
        #1 chk_cnt("sw_after", 16'd7, 1'b1);

        // sw stalled in MEMWR, reset pulsed mid-cycle.
        step("sw2_fetch", 4'd1, E_FETCH_R);
        step("sw2_decode", 4'd2, E_DECODE);
        mem_ready_i = 1'b0;
        step("sw2_memadr", 4'd3, E_MEMADR);
        step("sw2_memwr", 4'd6, E_MEMWR);
        #2 rst_i = 1'b1;
        #1;
        chk("sw2_rst/state", {28'd0, state_o}, 32'd0);
        chk("sw2_rst/ctl", {15'd0, ctl}, {15'd0, E_ZERO});
        chk_cnt("sw2_rst", 16'd0, 1'b0);
        @(negedge clk_i);
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        instr_op_i  = 6'b000010;
        step("wrap_rst", 4'd0, E_ZERO);

        // Preload 65535 retirements, then one j wraps the counter to 0.
        force dut.cnt_q = 16'hffff;
        #1;
        release dut.cnt_q;
        step("wrap_fetch", 4'd1, E_FETCH_R);
        step("wrap_decode", 4'd2, E_DECODE);
        #1 chk_cnt("wrap_jump", 16'hffff, 1'b0);
        step("wrap_jump", 4'd12, E_JUMP);
        #1 chk_cnt("wrap_after", 16'h0000, 1'b0);
        step("wrap_next", 4'd1, E_FETCH_R);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
